// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - write-back arbiter for the register file's single write port
module regfile_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [4:0]               alu_reg,
    input  logic [31:0]              alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [4:0]               mem_reg,
    input  logic [31:0]              mem_data,
    output logic [4:0]               reg_write,
    output logic                     regwrite_con,
    output logic [31:0]              write_data,
    input  logic [4:0]               rd_reg1,
    input  logic [4:0]               rd_reg2,
    output logic                     pending1,
    output logic                     pending2,
    output logic [$clog2(DEPTH):0]   buf_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    buf_reg_q  [DEPTH];
    logic [31:0]   buf_data_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [4:0]    reg_write_q, reg_write_d;
    logic          regwrite_con_q, regwrite_con_d;
    logic [31:0]   write_data_q, write_data_d;

    logic empty, full, starve_hit, alu_take, mem_take;
    logic grant_buf, grant_mem, bypass, enq;
    logic [PW-1:0] idx;
    logic hit1, hit2;

    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(DEPTH));
    assign starve_hit = !empty && (starve_q == SW'(STARVE_LIMIT));
    assign alu_ready  = !rst && !full;
    assign mem_ready  = !rst && !(starve_hit && (mem_reg != 5'd0));
    // Register-0 requests are accepted but never take the slot or a buffer entry.
    assign alu_take   = alu_valid && alu_ready && (alu_reg != 5'd0);
    assign mem_take   = mem_valid && mem_ready && (mem_reg != 5'd0);

    always_comb begin
        grant_buf = 1'b0;
        grant_mem = 1'b0;
        bypass    = 1'b0;
        if (starve_hit)     grant_buf = 1'b1;
        else if (mem_take)  grant_mem = 1'b1;
        else if (!empty)    grant_buf = 1'b1;
        else if (alu_take)  bypass    = 1'b1;
    end

    assign enq = alu_take && !bypass;

    always_comb begin
        head_d         = grant_buf ? head_q + PW'(1) : head_q;
        tail_d         = enq ? tail_q + PW'(1) : tail_q;
        count_d        = count_q + CW'(enq) - CW'(grant_buf);
        starve_d       = starve_q;
        if (grant_buf || empty)
            starve_d = '0;
        else if (grant_mem && (starve_q != SW'(STARVE_LIMIT)))
            starve_d = starve_q + SW'(1);
        regwrite_con_d = grant_buf || grant_mem || bypass;
        reg_write_d    = reg_write_q;
        write_data_d   = write_data_q;
        if (grant_buf) begin
            reg_write_d  = buf_reg_q[head_q];
            write_data_d = buf_data_q[head_q];
        end else if (grant_mem) begin
            reg_write_d  = mem_reg;
            write_data_d = mem_data;
        end else if (bypass) begin
            reg_write_d  = alu_reg;
            write_data_d = alu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            starve_q       <= '0;
            reg_write_q    <= '0;
            regwrite_con_q <= 1'b0;
            write_data_q   <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            starve_q       <= starve_d;
            reg_write_q    <= reg_write_d;
            regwrite_con_q <= regwrite_con_d;
            write_data_q   <= write_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            buf_reg_q[tail_q]  <= alu_reg;
            buf_data_q[tail_q] <= alu_data;
        end
    end

    // Lookup uses pre-edge contents, so a head being dequeued still reports pending.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (buf_reg_q[idx] == rd_reg1) hit1 = 1'b1;
                if (buf_reg_q[idx] == rd_reg2) hit2 = 1'b1;
            end
        end
    end

    assign pending1     = hit1 && (rd_reg1 != 5'd0);
    assign pending2     = hit2 && (rd_reg2 != 5'd0);
    assign buf_count    = count_q;
    assign reg_write    = reg_write_q;
    assign regwrite_con = regwrite_con_q;
    assign write_data   = write_data_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0, mem_valid = 1'b0;
    logic        alu_ready, mem_ready;
    logic [4:0]  alu_reg = '0, mem_reg = '0, rd_reg1 = '0, rd_reg2 = '0;
    logic [31:0] alu_data = '0, mem_data = '0;
    logic [4:0]  reg_write;
    logic        regwrite_con;
    logic [31:0] write_data;
    logic        pending1, pending2;
    logic [1:0]  buf_count;

    int checks = 0;
    int failures = 0;
    int k;
    logic [36:0] exp_q[$];
    logic [36:0] tbuf[$];

    regfile_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
        .reg_write(reg_write), .regwrite_con(regwrite_con), .write_data(write_data),
        .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .pending1(pending1), .pending2(pending2),
        .buf_count(buf_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [36:0] obs, input logic [36:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && regwrite_con) begin
            chk("wb_expected", 37'(exp_q.size() != 0), 37'd1);
            if (exp_q.size() != 0) chk("wb", {reg_write, write_data}, exp_q.pop_front());
        end
    end

    // src: 0 no write, 1 MEM, 2 buffer head, 3 ALU bypass
    task automatic cyc(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic exp_ar, input logic exp_mr, input int src);
        @(posedge clk);
        #1;
        alu_valid = av; alu_reg = ar; alu_data = ad;
        mem_valid = mv; mem_reg = mr; mem_data = md;
        if (src == 1) exp_q.push_back({mr, md});
        if (src == 3) exp_q.push_back({ar, ad});
        if (src == 2) begin
            chk("model_buf_nonempty", 37'(tbuf.size() != 0), 37'd1);
            if (tbuf.size() != 0) exp_q.push_back(tbuf.pop_front());
        end
        if (av && exp_ar && ar != 5'd0 && src != 3) tbuf.push_back({ar, ad});
        @(negedge clk);
        chk("alu_ready", 37'(alu_ready), 37'(exp_ar));
        if (mv) chk("mem_ready", 37'(mem_ready), 37'(exp_mr));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_alu_ready", 37'(alu_ready), 37'd0);
        chk("rst_mem_ready", 37'(mem_ready), 37'd0);
        chk("rst_outputs", {reg_write, write_data}, 37'd0);
        chk("rst_we", 37'(regwrite_con), 37'd0);
        chk("rst_count", 37'(buf_count), 37'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // idle bypass
        cyc(1, 5'd5, 32'h11, 0, 5'd0, 32'h0, 1, 1, 3);
        cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 0);
        chk("bypass_we", 37'(regwrite_con), 37'd1);
        chk("bypass_count", 37'(buf_count), 37'd0);
        cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 0);
        chk("hold_we", 37'(regwrite_con), 37'd0);
        chk("hold_out", {reg_write, write_data}, {5'd5, 32'h11});

        // collision
        cyc(1, 5'd8, 32'hA, 1, 5'd9, 32'hB, 1, 1, 1);
        rd_reg1 = 5'd8; rd_reg2 = 5'd9;
        cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 2);
        chk("coll_pending1", 37'(pending1), 37'd1);
        chk("coll_pending2", 37'(pending2), 37'd0);
        chk("coll_count", 37'(buf_count), 37'd1);
        cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 0);
        chk("coll_pending_clear", 37'(pending1), 37'd0);
        chk("coll_count_drain", 37'(buf_count), 37'd0);

        // register 0
        rd_reg1 = 5'd0;
        cyc(1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF, 1, 1, 0);
        chk("r0_pending", 37'(pending1), 37'd0);
        cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 0);
        chk("r0_no_write", 37'(regwrite_con), 37'd0);
        chk("r0_count", 37'(buf_count), 37'd0);

        // starvation: two buffered entries under continuous MEM traffic
        k = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(i < 2, (i == 0) ? 5'd20 : 5'd21, 32'h100 + 32'(i),
                1, 5'd3, 32'h300 + 32'(k),
                !(i >= 2 && i <= 5), (i != 5 && i != 10), (i != 5 && i != 10) ? 1 : 2);
            if (i == 3) chk("starve_full_count", 37'(buf_count), 37'd2);
            if (i != 5 && i != 10) k++;
        end
        cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 0);
        chk("starve_drained", 37'(buf_count), 37'd0);

        // full buffer: held ALU request, FIFO order
        k = 0;
        for (int i = 0; i < 11; i++) begin
            cyc(i <= 6, (i == 0) ? 5'd10 : (i == 1) ? 5'd11 : 5'd12,
                32'hA0 + 32'((i < 2) ? i : 2),
                1, 5'd4, 32'h400 + 32'(k),
                !((i >= 2 && i <= 5) || (i >= 7 && i <= 10)),
                (i != 5 && i != 10), (i != 5 && i != 10) ? 1 : 2);
            if (i != 5 && i != 10) k++;
        end
        cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 2);
        cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 0);
        chk("full_drained", 37'(buf_count), 37'd0);

        // asynchronous reset with two buffered entries and a write in flight
        cyc(1, 5'd14, 32'hE0, 1, 5'd3, 32'h500, 1, 1, 1);
        cyc(1, 5'd15, 32'hE1, 1, 5'd3, 32'h501, 1, 1, 1);
        @(posedge clk);
        #2;
        chk("pre_rst_we", 37'(regwrite_con), 37'd1);
        chk("pre_rst_count", 37'(buf_count), 37'd2);
        alu_valid = 1'b0; mem_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_we", 37'(regwrite_con), 37'd0);
        chk("arst_count", 37'(buf_count), 37'd0);
        chk("arst_alu_ready", 37'(alu_ready), 37'd0);
        chk("arst_mem_ready", 37'(mem_ready), 37'd0);
        exp_q.delete();
        tbuf.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 0);
        chk("post_rst_count", 37'(buf_count), 37'd0);
        chk("scoreboard_empty", 37'(exp_q.size()), 37'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
